// File: rtl/bounce_emulator.sv
// Contact-bounce stimulus source: plays an LFSR burst or a solid glitch
// on a registered pin, then holds the final level for a settle window.
module bounce_emulator #(
   parameter int          SETTLE_CYCLES = 4,
   parameter logic [7:0]  LFSR_SEED     = 8'hA5,
   parameter logic        INIT_LEVEL    = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       mode,
   input  logic       level_req,
   input  logic [3:0] bounce_len,
   output logic       noisysignal,
   output logic       busy,
   output logic       done,
   output logic [4:0] toggle_count
);

   // An all-zero seed would lock the LFSR up
   localparam logic [7:0] SEED =
      (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam int SW =
      (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      BOUNCE,
      SETTLE
   } state_t;

   state_t        r_state;
   logic [7:0]    r_lfsr;
   logic          r_stable;
   logic          r_mode;
   logic [3:0]    r_len;
   logic          r_target;
   logic [3:0]    r_bcnt;
   logic [SW-1:0] r_scnt;
   logic          r_ns;
   logic          r_busy;
   logic          r_done;
   logic [4:0]    r_tc;

   logic w_fb;
   logic w_ns_next;
   logic w_tc_inc;

   assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

   always_comb begin
      w_ns_next = r_ns;
      unique case (r_state)
         IDLE:    w_ns_next = r_stable;
         BOUNCE:  w_ns_next = r_mode ? ~r_stable : r_lfsr[0];
         SETTLE:  w_ns_next = r_target;
         default: w_ns_next = r_stable;
      endcase
   end

   assign w_tc_inc = r_busy && (w_ns_next != r_ns);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_lfsr   <= SEED;
         r_stable <= INIT_LEVEL;
         r_mode   <= 1'b0;
         r_len    <= 4'd0;
         r_target <= INIT_LEVEL;
         r_bcnt   <= 4'd0;
         r_scnt   <= '0;
         r_ns     <= INIT_LEVEL;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_tc     <= 5'd0;
      end else begin
         r_lfsr <= {r_lfsr[6:0], w_fb};
         r_ns   <= w_ns_next;
         r_done <= 1'b0;
         if (w_tc_inc && (r_tc != 5'd31)) begin
            r_tc <= r_tc + 5'd1;
         end
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_mode   <= mode;
                  r_len    <= bounce_len;
                  r_target <= mode ? r_stable : level_req;
                  r_tc     <= 5'd0;
                  r_busy   <= 1'b1;
                  r_bcnt   <= 4'd0;
                  r_scnt   <= '0;
                  r_state  <= (bounce_len == 4'd0) ? SETTLE : BOUNCE;
               end
            end
            BOUNCE: begin
               if (r_bcnt == r_len - 4'd1) begin
                  r_bcnt  <= 4'd0;
                  r_state <= SETTLE;
               end else begin
                  r_bcnt <= r_bcnt + 4'd1;
               end
            end
            SETTLE: begin
               if (r_scnt == S_LAST) begin
                  r_scnt   <= '0;
                  r_stable <= r_target;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= IDLE;
               end else begin
                  r_scnt <= r_scnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign noisysignal  = r_ns;
   assign busy         = r_busy;
   assign done         = r_done;
   assign toggle_count = r_tc;

endmodule

// File: tb/tb_bounce_emulator.sv
// Bench for bounce_emulator: directed scenarios plus random commands
// checked against a cycle-level reference model of the pin waveform.
module tb_bounce_emulator;

   localparam int         S    = 4;
   localparam logic [7:0] SEED = 8'hA5;
   localparam logic       INIT = 1'b0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   logic       level_req = 1'b0;
   logic [3:0] bounce_len = 4'd0;
   logic       noisysignal;
   logic       busy;
   logic       done;
   logic [4:0] toggle_count;

   int checks = 0;
   int failures = 0;

   logic [7:0] m_lfsr;
   logic       m_stable = INIT;

   bounce_emulator #(
      .SETTLE_CYCLES (S),
      .LFSR_SEED     (SEED),
      .INIT_LEVEL    (INIT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .mode         (mode),
      .level_req    (level_req),
      .bounce_len   (bounce_len),
      .noisysignal  (noisysignal),
      .busy         (busy),
      .done         (done),
      .toggle_count (toggle_count)
   );

   always #5 clk = ~clk;

   // x^8+x^6+x^5+x^4+1, shift toward msb, new bit enters at bit 0
   function automatic logic [7:0] step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= SEED;
      else        m_lfsr <= step(m_lfsr);
   end

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_cmd(input logic md, input logic lv,
                          input logic [3:0] len, input bit hammer);
      logic [7:0] lf;
      logic       tgt;
      logic       prev;
      logic       exp;
      int         tog;
      int         total;
      @(negedge clk);
      start      = 1'b1;
      mode       = md;
      level_req  = lv;
      bounce_len = len;
      @(posedge clk);
      #1;
      start = 1'b0;
      lf    = m_lfsr;
      tgt   = md ? m_stable : lv;
      prev  = m_stable;
      tog   = 0;
      total = int'(len) + S;
      chk("busy_accept", 8'(busy), 8'd1);
      chk("tc_clear", 8'(toggle_count), 8'd0);
      chk("pin_e0", 8'(noisysignal), 8'(m_stable));
      for (int k = 1; k <= total; k++) begin
         if (hammer) begin
            start      = 1'b1;
            mode       = 1'($urandom);
            level_req  = 1'($urandom);
            bounce_len = 4'($urandom);
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (k <= int'(len)) begin
            exp = md ? ~m_stable : lf[0];
            lf  = step(lf);
         end else begin
            exp = tgt;
         end
         chk("pin", 8'(noisysignal), 8'(exp));
         if (exp != prev && tog < 31) tog++;
         prev = exp;
         chk("busy", 8'(busy), 8'(k < total));
         chk("done", 8'(done), 8'(k == total));
      end
      chk("toggle_count", 8'(toggle_count), 8'(tog));
      m_stable = tgt;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pin", 8'(noisysignal), 8'(INIT));
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_done", 8'(done), 8'd0);
      chk("rst_tc", 8'(toggle_count), 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // clean rise, then back to 0, then a one-cycle glitch
      run_cmd(1'b0, 1'b1, 4'd0, 1'b0);
      run_cmd(1'b0, 1'b0, 4'd0, 1'b0);
      run_cmd(1'b1, 1'b0, 4'd1, 1'b0);
      run_cmd(1'b1, 1'b0, 4'd0, 1'b0);

      // abort mid-burst with reset
      @(negedge clk);
      start      = 1'b1;
      mode       = 1'b0;
      level_req  = 1'b1;
      bounce_len = 4'd10;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_pin", 8'(noisysignal), 8'(INIT));
      chk("abort_busy", 8'(busy), 8'd0);
      chk("abort_done", 8'(done), 8'd0);
      chk("abort_tc", 8'(toggle_count), 8'd0);
      m_stable = INIT;
      @(negedge clk);
      rst_n = 1'b1;

      // full-length bounced rise from a fresh seed
      run_cmd(1'b0, 1'b1, 4'd15, 1'b0);

      // starts hammered while busy, then a start in the done cycle
      run_cmd(1'b0, 1'b0, 4'd6, 1'b1);
      run_cmd(1'b1, 1'b0, 4'd2, 1'b0);
      run_cmd(1'b0, 1'b0, 4'd3, 1'b0);

      repeat (40) begin
         int gap;
         gap = int'($urandom_range(2, 0));
         for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            chk("idle_pin", 8'(noisysignal), 8'(m_stable));
            chk("idle_busy", 8'(busy), 8'd0);
         end
         run_cmd(1'($urandom), 1'($urandom), 4'($urandom),
                 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
